relu_vec_pipe: RTL and testbench

Multi-lane, mode-selectable FP32 activation unit: the parametrised successor to the single-lane registered ReLU. It applies ReLU, leaky ReLU with a power-of-two slope, clamped ReLU, or pass-through to LANES IEEE-754 single-precision words per beat. It sits between the MAC/accumulator output and the writeback buffer, and carries a valid/ready stream with backpressure. A saturating per-block zero counter supports sparsity statistics.

---
 rtl/relu_vec_pipe_if.sv | 23 ++
 rtl/relu_vec_pipe.sv | 148 ++++++++++++++
 tb/tb_relu_vec_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_vec_pipe_if.sv
// Valid/ready stream bundle for relu_vec_pipe: input beat with mode, output beat.
// The slave modport is the activation unit's view and the master modport is the driver's view.
interface relu_vec_pipe_if #(
  parameter int unsigned LANES = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [LANES*32-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/relu_vec_pipe.sv
// Multi-lane FP32 activation (ReLU / leaky / clamp / pass), two-stage valid/ready pipe
// with a saturating count of lanes forced to +0.
module relu_vec_pipe #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter logic [31:0] CLAMP_VAL  = 32'h40C00000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  relu_vec_pipe_if.slave    io_bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  zero_cnt
);

  localparam int unsigned DW = LANES * 32;
  localparam int unsigned ZW = $clog2(LANES + 1);
  localparam int unsigned SW = ((CNT_W > ZW) ? CNT_W : ZW) + 1;

  typedef enum logic [1:0] {
    MODE_RELU  = 2'd0,
    MODE_LEAKY = 2'd1,
    MODE_CLAMP = 2'd2,
    MODE_PASS  = 2'd3
  } mode_e;

  // Returns {forced_to_pos_zero, result} for one lane.
  function automatic logic [32:0] act_lane(input logic [31:0] x, input logic [1:0] mode);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] r;
    logic        z;
    s = x[31];
    e = x[30:23];
    m = x[22:0];
    r = x;
    z = 1'b0;
    if (e == 8'hFF && m != 23'd0) begin
      r = 32'h7FC00000;
    end else begin
      case (mode_e'(mode))
        MODE_RELU: begin
          if (s) begin
            r = 32'd0;
            z = 1'b1;
          end
        end
        MODE_LEAKY: begin
          // -inf keeps its value; small magnitudes underflow to +0
          if (s && e != 8'hFF) begin
            if (e > 8'(LEAK_SHIFT)) begin
              r = {1'b1, e - 8'(LEAK_SHIFT), m};
            end else begin
              r = 32'd0;
              z = 1'b1;
            end
          end
        end
        MODE_CLAMP: begin
          if (s) begin
            r = 32'd0;
            z = 1'b1;
          end else if (x[30:0] > CLAMP_VAL[30:0]) begin
            r = CLAMP_VAL;
          end
        end
        default: r = x;
      endcase
    end
    return {z, r};
  endfunction

  logic              w_adv;
  logic [DW-1:0]     w_s1_data;
  logic [LANES-1:0]  w_zero;
  logic [ZW-1:0]     w_s1_zcnt;
  logic              w_out_hs;
  logic [SW-1:0]     w_sum;

  logic              r_s1_valid;
  logic [DW-1:0]     r_s1_data;
  logic [ZW-1:0]     r_s1_zcnt;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;
  logic [ZW-1:0]     r_out_zcnt;
  logic [CNT_W-1:0]  r_cnt;

  assign w_adv    = !r_out_valid || io_bus.out_ready;
  assign w_out_hs = r_out_valid && io_bus.out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign {w_zero[g], w_s1_data[g*32 +: 32]} = act_lane(io_bus.in_data[g*32 +: 32], io_bus.in_mode);
  end

  always_comb begin
    w_s1_zcnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_s1_zcnt = w_s1_zcnt + ZW'(w_zero[i]);
    end
  end

  // S1 compute register and S2 output register, both frozen on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_zcnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zcnt  <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= io_bus.in_valid;
      r_out_valid <= r_s1_valid;
      if (io_bus.in_valid) begin
        r_s1_data <= w_s1_data;
        r_s1_zcnt <= w_s1_zcnt;
      end
      if (r_s1_valid) begin
        r_out_data <= r_s1_data;
        r_out_zcnt <= r_s1_zcnt;
      end
    end
  end

  assign w_sum = SW'(r_cnt) + SW'(r_out_zcnt);

  // Clear has priority over the increment of the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_hs) begin
      if (w_sum > SW'({CNT_W{1'b1}})) begin
        r_cnt <= {CNT_W{1'b1}};
      end else begin
        r_cnt <= CNT_W'(w_sum);
      end
    end
  end

  assign io_bus.in_ready  = w_adv;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign zero_cnt         = r_cnt;

endmodule

// File: tb/tb_relu_vec_pipe.sv
// Directed bench for relu_vec_pipe: per-mode vector table plus backpressure,
// counter saturation/clear and mid-stream reset sequences.
module tb_relu_vec_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             cnt_clr;
  logic [CNT_W-1:0] zero_cnt;

  relu_vec_pipe_if #(.LANES(LANES)) bus ();

  relu_vec_pipe #(
    .LANES(LANES), .LEAK_SHIFT(3), .CLAMP_VAL(32'h40C00000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus.slave), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // in_ready must always be the advance condition
  always @(negedge clk) begin
    checks++;
    if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", bus.in_ready, !bus.out_valid || bus.out_ready);
    end
  end

  typedef struct packed {
    logic [1:0]   mode;
    logic [127:0] din;
    logic [127:0] dout;
    logic [3:0]   nz;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] ALL_NEG = {4{32'hBF800000}};

  initial begin : main
    logic [127:0] bdin  [6];
    logic [127:0] bexp  [6];
    logic [1:0]   bmode [6];
    int           pat   [6];
    logic [127:0] held;
    logic         stalled;
    int           tx, rx, cyc;

    // lanes written {lane3, lane2, lane1, lane0}
    vecs[0] = '{2'd0, {32'h7F800000, 32'h80000000, 32'h3F800000, 32'hBF800000},
                      {32'h7F800000, 32'h00000000, 32'h3F800000, 32'h00000000}, 4'd2};
    vecs[1] = '{2'd1, {32'hFF800000, 32'h80800000, 32'hC0000000, 32'hBF800000},
                      {32'hFF800000, 32'h00000000, 32'hBE800000, 32'hBE000000}, 4'd1};
    vecs[2] = '{2'd2, {32'hC1200000, 32'h7F800000, 32'h40A00000, 32'h40E00000},
                      {32'h00000000, 32'h40C00000, 32'h40A00000, 32'h40C00000}, 4'd1};
    vecs[3] = '{2'd3, {32'hFFC00000, 32'h00000000, 32'hBF800000, 32'h7FA00001},
                      {32'h7FC00000, 32'h00000000, 32'hBF800000, 32'h7FC00000}, 4'd0};
    vecs[4] = '{2'd0, {32'h00000001, 32'h80000001, 32'h00000000, 32'h7FA00001},
                      {32'h00000001, 32'h00000000, 32'h00000000, 32'h7FC00000}, 4'd1};
    vecs[5] = '{2'd1, {32'h3F800000, 32'h82000000, 32'h81800000, 32'h7FA00001},
                      {32'h3F800000, 32'h80800000, 32'h00000000, 32'h7FC00000}, 4'd1};
    vecs[6] = '{2'd2, {32'h80000000, 32'h40C00001, 32'h40C00000, 32'h7FA00001},
                      {32'h00000000, 32'h40C00000, 32'h40C00000, 32'h7FC00000}, 4'd1};
    vecs[7] = '{2'd2, {32'h00000000, 32'h3F800000, 32'h7F7FFFFF, 32'hFF800000},
                      {32'h00000000, 32'h3F800000, 32'h40C00000, 32'h00000000}, 4'd1};

    rst           = 1'b1;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_zero_cnt", 128'(zero_cnt), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    step();
    step();
    #3 rst = 1'b0;
    step();

    // table: one beat per vector, latency and per-beat zero count
    for (int v = 0; v < 8; v++) begin
      cnt_clr = 1'b1;
      step();
      cnt_clr      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_mode  = vecs[v].mode;
      bus.in_data  = vecs[v].din;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      chk($sformatf("v%0d_lat1", v), 128'(bus.out_valid), 128'(0));
      step();
      chk($sformatf("v%0d_valid", v), 128'(bus.out_valid), 128'(1));
      chk($sformatf("v%0d_data", v), bus.out_data, vecs[v].dout);
      step();
      chk($sformatf("v%0d_zcnt", v), 128'(zero_cnt), 128'(vecs[v].nz));
      chk($sformatf("v%0d_drain", v), 128'(bus.out_valid), 128'(0));
    end

    // backpressure: 6 beats alternating ReLU/pass, out_ready cycling 1,0,0,1,0,1
    pat = '{1, 0, 0, 1, 0, 1};
    for (int k = 0; k < 6; k++) begin
      bmode[k] = (k % 2 == 1) ? 2'd3 : 2'd0;
      bdin[k]  = {32'h3F800000 + 32'(k*16 + 3), 32'h3F800000 + 32'(k*16 + 2),
                  32'h3F800000 + 32'(k*16 + 1), 32'hBF800000 | 32'(k)};
      bexp[k]  = bdin[k];
      if (bmode[k] == 2'd0) bexp[k][31:0] = 32'h00000000;
    end
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rx < 6 && cyc < 100) begin
      bus.out_ready = (pat[cyc % 6] != 0);
      bus.in_valid  = (tx < 6);
      if (tx < 6) begin
        bus.in_data = bdin[tx];
        bus.in_mode = bmode[tx];
      end
      #1;
      if (stalled) begin
        chk("bp_stall_valid", 128'(bus.out_valid), 128'(1));
        chk("bp_stall_hold", bus.out_data, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_beat%0d", rx), bus.out_data, bexp[rx]);
        rx++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.in_valid && bus.in_ready) tx++;
      step();
      cyc++;
    end
    chk("bp_received", 128'(rx), 128'(6));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_no_dup", 128'(bus.out_valid), 128'(0));

    // counter: 3 then 2 all-negative ReLU beats, saturation at F
    cnt_clr = 1'b1;
    step();
    cnt_clr     = 1'b0;
    bus.in_mode = 2'd0;
    bus.in_data = ALL_NEG;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("cnt_12", 128'(zero_cnt), 128'(12));
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("cnt_sat", 128'(zero_cnt), 128'(15));

    // clear coinciding with a handshake wins
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("clr_valid", 128'(bus.out_valid), 128'(1));
    cnt_clr = 1'b1;
    step();
    chk("clr_wins", 128'(zero_cnt), 128'(0));
    cnt_clr = 1'b0;
    step();
    chk("clr_stays", 128'(zero_cnt), 128'(0));

    // reset with two beats in flight
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("pre_rst_cnt", 128'(zero_cnt), 128'(4));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_cnt", 128'(zero_cnt), 128'(0));
    chk("arst_data", bus.out_data, 128'(0));
    step();
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_idle", 128'(bus.out_valid), 128'(0));
    step();
    chk("post_rst_idle2", 128'(bus.out_valid), 128'(0));
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'd0;
    bus.in_data  = {4{32'h3F800000}};
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_lat1", 128'(bus.out_valid), 128'(0));
    step();
    chk("post_rst_valid", 128'(bus.out_valid), 128'(1));
    chk("post_rst_data", bus.out_data, {4{32'h3F800000}});
    step();
    chk("post_rst_cnt", 128'(zero_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
